booth_arbitru: RTL and testbench
================================

BOOTH_ARBITRU -- requirements
Module: booth_arbitru

Interface
REQ-001 Parameters: none; operand width (4 bits) and product width (8 bits) SHALL be fixed by the shared multiplier.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester 0 / 1.
REQ-005 m0, r0, m1, r1  input  4 each  signed two's-complement multiplicand / multiplier per requester; held stable by the requester while its req is high.
REQ-006 ack0, ack1  output  1 each  one-cycle completion pulse per requester.
REQ-007 p  output  8  signed product, valid only in a cycle where ack0 or ack1 is high.
REQ-008 busy  output  1  high in any state other than IDLE.

Function
REQ-009 The FSM SHALL have three states: IDLE, CALC and RESP.
REQ-010 IDLE with no req high: SHALL remain in IDLE.
REQ-011 IDLE with any req high: SHALL grant one requester, latch its m/r into operand registers, record the grant, and go to CALC.
REQ-012 CALC: the multiplier output SHALL be registered into the product register; the FSM SHALL then go to RESP.
REQ-013 RESP: SHALL pulse ack of the granted port for exactly one cycle, drive p from the product register, update last_grant, and return to IDLE.
REQ-014 Latency: with req sampled high in IDLE at edge N, ack SHALL be high during the cycle following edge N+2; throughput is one product per 3 cycles.
REQ-015 Arbitration SHALL be round-robin: on a tie, the port not recorded in last_grant SHALL win; a single request SHALL be granted regardless of last_grant.
REQ-016 A requester that keeps req high after its ack SHALL be treated as a new request in the next IDLE cycle.
REQ-017 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the operation, and ack SHALL still pulse.
REQ-018 ack0 and ack1 SHALL never be high in the same cycle.
REQ-019 p SHALL be 8'h00 whenever neither ack is high.
REQ-020 Arithmetic SHALL be signed: the product SHALL equal sign-extended m times sign-extended r, with no overflow for any 4-bit input pair.

Reset
REQ-021 Asserting reset SHALL immediately force state IDLE, ack0=ack1=0, p=8'h00, busy=0, operand and product registers to 0, and last_grant=1, so port 0 wins the first tie.
REQ-022 Reset during CALC or RESP SHALL discard the operation, with no ack issued after reset deasserts.
REQ-023 The first grant SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-024 Macro BOOTH_ARB_STATS_EN, when defined, SHALL add outputs cnt0 and cnt1 (8 bits each), saturating at 8'hFF, each incremented on every ack of its port and cleared by reset.
REQ-025 Without BOOTH_ARB_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 A shared header/package SHALL hold the state encodings (IDLE=2'd0, CALC=2'd1, RESP=2'd2) and the width constants OP_W=4 and P_W=8.
REQ-027 The block SHALL contain exactly one sub-module instance, booth_inmultire (ports m, r, p), driven from the operand registers.

Verification
REQ-028 Single requester: req0 with m0=4, r0=2 -> ack0 three cycles later, p=8'h08, ack1 stays 0.
REQ-029 Signed operands: req1 with m1=-3 (4'hD), r1=5 -> ack1 with p=8'hF1; and m1=-8, r1=-8 -> p=8'h40.
REQ-030 Tie after reset: req0 and req1 both held high continuously with distinct operands -> grant order 0,1,0,1, acks spaced 3 cycles apart, each p correct.
REQ-031 Early withdrawal: req0 pulsed for one cycle while busy serving port 1 -> no ack0 is ever issued; req0 pulsed in IDLE -> ack0 is issued.
REQ-032 Reset mid-operation: reset asserted during CALC -> outputs cleared immediately, no spurious ack after release; the next tie is granted to port 0.
REQ-033 With BOOTH_ARB_STATS_EN: 300 back-to-back port-0 requests -> cnt0 saturates at 8'hFF, cnt1=0.

Source files
------------

// File: rtl/booth_arbitru_pkg.sv
// Shared constants for the booth_arbitru multiplier arbiter:
// the FSM state encodings and the fixed operand and product widths.
package booth_arbitru_pkg;

    localparam int OP_W = 4;
    localparam int P_W  = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/booth_arbitru_inmultire.sv
// booth_inmultire: combinational radix-2 Booth signed multiplier.
// Computes an OP_W x OP_W signed product into P_W bits, which never overflows.
module booth_inmultire
    import booth_arbitru_pkg::*;
(
    input  logic [OP_W-1:0] m,
    input  logic [OP_W-1:0] r,
    output logic [P_W-1:0]  p
);

    logic [P_W-1:0]  w_mext;
    logic [OP_W:0]   w_rx;
    logic [P_W-1:0]  w_acc;

    // Scan the multiplier bit pairs {r[i], r[i-1]}. A pair of 01 adds the
    // shifted multiplicand and a pair of 10 subtracts it. The result is
    // taken mod 2^P_W.
    always_comb begin
        w_mext = {{(P_W-OP_W){m[OP_W-1]}}, m};
        w_rx   = {r, 1'b0};
        w_acc  = '0;
        for (int i = 0; i < OP_W; i++) begin
            case (w_rx[i+1 -: 2])
                2'b01:   w_acc = w_acc + (w_mext << i);
                2'b10:   w_acc = w_acc - (w_mext << i);
                default: w_acc = w_acc;
            endcase
        end
        p = w_acc;
    end

endmodule

// File: rtl/booth_arbitru.sv
// booth_arbitru: two-port round-robin arbiter in front of one shared Booth multiplier.
// Each operation runs IDLE (grant and latch) -> CALC (register the product)
// -> RESP (registered ack and p, which appear in the following cycle).
// Optional macro BOOTH_ARB_STATS_EN adds saturating per-port ack counters cnt0 and cnt1.
module booth_arbitru
    import booth_arbitru_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic [OP_W-1:0] m0,
    input  logic [OP_W-1:0] r0,
    input  logic [OP_W-1:0] m1,
    input  logic [OP_W-1:0] r1,
    output logic            ack0,
    output logic            ack1,
    output logic [P_W-1:0]  p,
    output logic            busy
`ifdef BOOTH_ARB_STATS_EN
    ,
    output logic [P_W-1:0]  cnt0,
    output logic [P_W-1:0]  cnt1
`endif
);

    logic [1:0]      r_state;
    logic [OP_W-1:0] r_m;
    logic [OP_W-1:0] r_r;
    logic [P_W-1:0]  r_prod;
    logic            r_grant;
    logic            r_last_grant;
    logic            r_ack0;
    logic            r_ack1;
    logic [P_W-1:0]  r_p;

    logic [P_W-1:0]  w_mul_p;
    logic            w_any;
    logic            w_pick;

    booth_inmultire u_mul (
        .m (r_m),
        .r (r_r),
        .p (w_mul_p)
    );

    // Choose the winner: on a tie, the port not served last wins; otherwise the sole requester wins.
    always_comb begin
        w_any  = req0 | req1;
        w_pick = (req0 && req1) ? ~r_last_grant : req1;
    end

    // FSM, operand and product registers, and the registered ack/p outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_m          <= '0;
            r_r          <= '0;
            r_prod       <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_p          <= '0;
        end else begin
            // ack and p are one-cycle pulses, so they are cleared by default.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_p    <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_m     <= w_pick ? m1 : m0;
                        r_r     <= w_pick ? r1 : r0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_prod  <= w_mul_p;
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack0       <= ~r_grant;
                    r_ack1       <= r_grant;
                    r_p          <= r_prod;
                    r_last_grant <= r_grant;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign p    = r_p;
    assign busy = (r_state != IDLE);

`ifdef BOOTH_ARB_STATS_EN
    logic [P_W-1:0] r_cnt0;
    logic [P_W-1:0] r_cnt1;

    // Saturating ack counters. They advance on the same edge that raises the matching ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (r_state == RESP) begin
            if (!r_grant && r_cnt0 != {P_W{1'b1}}) r_cnt0 <= r_cnt0 + 1'b1;
            if (r_grant && r_cnt1 != {P_W{1'b1}})  r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_booth_arbitru.sv
// Directed testbench for booth_arbitru: a single-request vector table plus
// hand-written sequences for tie, withdrawal and mid-operation reset cases.
module tb_booth_arbitru;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [3:0] m0, r0, m1, r1;
    logic       ack0, ack1;
    logic [7:0] p;
    logic       busy;
`ifdef BOOTH_ARB_STATS_EN
    logic [7:0] cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;

    booth_arbitru dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .m0    (m0),
        .r0    (r0),
        .m1    (m1),
        .r1    (r1),
        .ack0  (ack0),
        .ack1  (ack1),
        .p     (p),
        .busy  (busy)
`ifdef BOOTH_ARB_STATS_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Invariants checked every cycle: the two acks are never high together, and p is zero when no ack is high.
    always @(negedge clk) begin
        if (!reset) begin
            check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
            if (!ack0 && !ack1) check("p_idle_zero", {24'd0, p}, 32'd0);
        end
    end

    typedef struct {
        logic       port;
        logic [3:0] m;
        logic [3:0] r;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[10];

    // Issue a one-shot request. req is dropped right after the grant. The
    // exact 3-cycle ack timing and the product are checked.
    task automatic run_one(input logic port, input logic [3:0] m, input logic [3:0] r,
                           input logic [7:0] exp);
        if (port) begin m1 = m; r1 = r; req1 = 1'b1; end
        else      begin m0 = m; r0 = r; req0 = 1'b1; end
        @(negedge clk);
        check("calc_busy", {31'd0, busy}, 32'd1);
        check("calc_noack", {30'd0, ack1, ack0}, 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("resp_noack", {30'd0, ack1, ack0}, 32'd0);
        @(negedge clk);
        check("ack_port", {30'd0, ack1, ack0}, port ? 32'd2 : 32'd1);
        check("product", {24'd0, p}, {24'd0, exp});
        @(negedge clk);
        check("ack_single", {30'd0, ack1, ack0}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cyc, last, seen0, seen1;
        logic found;

        vecs[0] = '{1'b0, 4'd4,  4'd2,  8'h08};
        vecs[1] = '{1'b1, 4'hD,  4'd5,  8'hF1};
        vecs[2] = '{1'b1, 4'h8,  4'h8,  8'h40};
        vecs[3] = '{1'b0, 4'd7,  4'd7,  8'h31};
        vecs[4] = '{1'b0, 4'h8,  4'd7,  8'hC8};
        vecs[5] = '{1'b1, 4'hF,  4'hF,  8'h01};
        vecs[6] = '{1'b0, 4'd0,  4'hB,  8'h00};
        vecs[7] = '{1'b1, 4'd7,  4'h8,  8'hC8};
        vecs[8] = '{1'b0, 4'hB,  4'd3,  8'hF1};
        vecs[9] = '{1'b1, 4'd3,  4'hA,  8'hEE};

        reset = 1'b1; req0 = 0; req1 = 0; m0 = 0; r0 = 0; m1 = 0; r1 = 0;
        @(negedge clk);
        check("rst_outputs", {21'd0, busy, ack1, ack0, p}, 32'd0);
        reset = 1'b0;

        // Table of single-requester operations.
        for (int i = 0; i < 10; i++)
            run_one(vecs[i].port, vecs[i].m, vecs[i].r, vecs[i].p);

        // Tie after reset: grants alternate 0,1,0,1 at 3-cycle spacing.
        do_reset();
        m0 = 4'd2; r0 = 4'd3; m1 = 4'hE; r1 = 4'd4;
        req0 = 1'b1; req1 = 1'b1;
        cyc = 0; last = 0;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int t = 0; t < 6 && !found; t++) begin
                @(negedge clk);
                cyc++;
                if (ack0 || ack1) found = 1'b1;
            end
            if (!found) begin
                errors++; checks++;
                $display("FAIL tie_timeout actual=none expected=ack%0d", k % 2);
            end else begin
                check("tie_port", {30'd0, ack1, ack0}, (k % 2) ? 32'd2 : 32'd1);
                check("tie_p", {24'd0, p}, (k % 2) ? 32'hF8 : 32'h06);
                check("tie_gap", cyc - last, 32'd3);
                last = cyc;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

        // Early withdrawal: a one-cycle req0 pulse while port 1 is being served is ignored.
        m1 = 4'd1; r1 = 4'd1; m0 = 4'd3; r0 = 4'd3;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        seen0 = 0; seen1 = 0;
        for (int t = 0; t < 8; t++) begin
            if (ack0) seen0++;
            if (ack1) seen1++;
            @(negedge clk);
        end
        check("wd_no_ack0", seen0, 32'd0);
        check("wd_ack1_once", seen1, 32'd1);
        // A one-cycle req0 pulse in IDLE is granted.
        run_one(1'b0, 4'd3, 4'd3, 8'h09);

        // Reset during CALC: outputs clear at once, and no ack appears after release.
        m0 = 4'd5; r0 = 4'd5;
        req0 = 1'b1;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        #1 reset = 1'b1;
        #1 check("rst_mid_out", {21'd0, busy, ack1, ack0, p}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen0 = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) seen0++;
        end
        check("rst_no_spurious", seen0, 32'd0);
        // The next tie goes to port 0 because reset restored the round-robin pointer.
        m0 = 4'd1; r0 = 4'd6; m1 = 4'd2; r1 = 4'd2;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tie_port0", {30'd0, ack1, ack0}, 32'd1);
        check("rst_tie_p", {24'd0, p}, 32'h06);
        repeat (6) @(negedge clk);

`ifdef BOOTH_ARB_STATS_EN
        do_reset();
        check("cnt_reset", {16'd0, cnt1, cnt0}, 32'd0);
        m0 = 4'd1; r0 = 4'd1;
        req0 = 1'b1;
        repeat (900) @(negedge clk);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        check("cnt0_sat", {24'd0, cnt0}, 32'hFF);
        check("cnt1_zero", {24'd0, cnt1}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
